// File: rtl/uart_io_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_io_bridge_if
// Groups the processor IO-port bus and the TX/RX byte streams of the
// uart_io_bridge into one bundle.
//
// Signals:
//   IO_port_ID      port address from processor
//   IO_write_data   write data from processor
//   IO_write_strobe one write access per clock edge while high
//   IO_read_strobe  one read access per clock edge while high
//   IO_read_data    combinational read data to processor
//   tx_data/valid   TX FIFO head byte, first-word fall-through
//   tx_ready        downstream accepts tx_data
//   rx_data/valid   incoming byte stream
//   rx_ready        RX FIFO can accept
//   irq             level interrupt request
//
// Modports: master = processor plus stream endpoints, slave = the bridge.
// -----------------------------------------------------------------------------
interface uart_io_bridge_if;
    logic [7:0] IO_port_ID;
    logic [7:0] IO_write_data;
    logic       IO_write_strobe;
    logic       IO_read_strobe;
    logic [7:0] IO_read_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       irq;

    modport master (
        output IO_port_ID,
        output IO_write_data,
        output IO_write_strobe,
        output IO_read_strobe,
        input  IO_read_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  irq
    );

    modport slave (
        input  IO_port_ID,
        input  IO_write_data,
        input  IO_write_strobe,
        input  IO_read_strobe,
        output IO_read_data,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output irq
    );
endinterface

// File: rtl/uart_io_bridge.sv
// -----------------------------------------------------------------------------
// uart_io_bridge
// Maps a TX FIFO and an RX FIFO onto four consecutive processor IO ports:
//   BASE_ID+0 DATA   write pushes TX, read pops RX (8'h00 if RX empty)
//   BASE_ID+1 RXPRES 8'hFF if RX holds data
//   BASE_ID+2 TXFULL 8'hFF if TX is full
//   BASE_ID+3 STAT   {tx_ovf, rx_unf, 2'b0, tx_empty, rx_full, tx_full, rx_nempty}
//                    writing 1 to bit7/bit6 clears tx_ovf/rx_unf
// With LOOPBACK set, TX bytes are moved straight into the RX FIFO and the
// external stream handshakes are disabled.
//
// Ports:
//   clk100  sole clock, rising edge
//   reset   asynchronous, active-high; empties both FIFOs and clears flags
//   bus     uart_io_bridge_if.slave (processor bus, TX and RX streams, irq)
// -----------------------------------------------------------------------------
module uart_io_bridge #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [7:0]  BASE_ID  = 8'h01,
    parameter bit          LOOPBACK = 1'b0
) (
    input logic             clk100,
    input logic             reset,
    uart_io_bridge_if.slave bus
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    localparam logic [7:0] IdData   = BASE_ID;
    localparam logic [7:0] IdRxPres = BASE_ID + 8'd1;
    localparam logic [7:0] IdTxFull = BASE_ID + 8'd2;
    localparam logic [7:0] IdStat   = BASE_ID + 8'd3;

    // ---------------------------------------------------------------- state
    logic [7:0]      tx_mem_q [DEPTH];
    logic [PtrW-1:0] tx_wptr_q, tx_wptr_d;
    logic [PtrW-1:0] tx_rptr_q, tx_rptr_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;

    logic [7:0]      rx_mem_q [DEPTH];
    logic [PtrW-1:0] rx_wptr_q, rx_wptr_d;
    logic [PtrW-1:0] rx_rptr_q, rx_rptr_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;

    logic tx_ovf_q, tx_ovf_d;
    logic rx_unf_q, rx_unf_d;

    // ---------------------------------------------------------------- status
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0] tx_head, rx_head, stat_val;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == DepthCnt);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == DepthCnt);
    assign tx_head  = tx_mem_q[tx_rptr_q];
    assign rx_head  = rx_mem_q[rx_rptr_q];
    assign stat_val = {tx_ovf_q, rx_unf_q, 2'b00, tx_empty, rx_full, tx_full, !rx_empty};

    // ---------------------------------------------------------------- decode
    logic sel_data, sel_rxpres, sel_txfull, sel_stat;
    logic wr_data, rd_data, wr_stat;

    assign sel_data   = (bus.IO_port_ID == IdData);
    assign sel_rxpres = (bus.IO_port_ID == IdRxPres);
    assign sel_txfull = (bus.IO_port_ID == IdTxFull);
    assign sel_stat   = (bus.IO_port_ID == IdStat);

    assign wr_data = bus.IO_write_strobe & sel_data;
    assign rd_data = bus.IO_read_strobe & sel_data;
    assign wr_stat = bus.IO_write_strobe & sel_stat;

    // ---------------------------------------------------------------- FIFO control
    logic       lb_move;
    logic       tx_push, tx_pop, tx_drop;
    logic       rx_push, rx_pop, rx_under;
    logic [7:0] rx_push_data;

    assign lb_move = LOOPBACK & !tx_empty & !rx_full;

    assign tx_pop  = LOOPBACK ? lb_move : (!tx_empty & bus.tx_ready);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign tx_push = wr_data & (!tx_full | tx_pop);
    assign tx_drop = wr_data & tx_full & !tx_pop;

    assign rx_push      = LOOPBACK ? lb_move : (bus.rx_valid & !rx_full);
    assign rx_push_data = LOOPBACK ? tx_head : bus.rx_data;
    assign rx_pop       = rd_data & !rx_empty;
    assign rx_under     = rd_data & rx_empty;

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
        if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
        if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // Sticky error flags; a new event on the clearing edge wins.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (wr_stat && bus.IO_write_data[7]) tx_ovf_d = 1'b0;
        if (wr_stat && bus.IO_write_data[6]) rx_unf_d = 1'b0;
        if (tx_drop)  tx_ovf_d = 1'b1;
        if (rx_under) rx_unf_d = 1'b1;
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_unf_q  <= rx_unf_d;
        end
    end

    // Storage is not reset; pointers and counts define what is valid.
    always_ff @(posedge clk100) begin
        if (tx_push && !reset) tx_mem_q[tx_wptr_q] <= bus.IO_write_data;
        if (rx_push && !reset) rx_mem_q[rx_wptr_q] <= rx_push_data;
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.IO_read_data = 8'h00;
        if (bus.IO_read_strobe) begin
            if (sel_data)        bus.IO_read_data = rx_empty ? 8'h00 : rx_head;
            else if (sel_rxpres) bus.IO_read_data = rx_empty ? 8'h00 : 8'hFF;
            else if (sel_txfull) bus.IO_read_data = tx_full ? 8'hFF : 8'h00;
            else if (sel_stat)   bus.IO_read_data = stat_val;
            else                 bus.IO_read_data = 8'hFF;
        end
    end

    assign bus.tx_data  = tx_head;
    assign bus.tx_valid = LOOPBACK ? 1'b0 : !tx_empty;
    assign bus.rx_ready = LOOPBACK ? 1'b0 : !rx_full;
    assign bus.irq      = !rx_empty | tx_ovf_q | rx_unf_q;

endmodule

// File: tb/tb_uart_io_bridge.sv
module tb_uart_io_bridge;

    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  BASE  = 8'h01;

    logic clk100 = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk100 = ~clk100;

    uart_io_bridge_if bus ();
    uart_io_bridge_if lb_bus ();

    uart_io_bridge #(.DEPTH(DEPTH), .BASE_ID(BASE), .LOOPBACK(1'b0)) dut (
        .clk100 (clk100),
        .reset  (reset),
        .bus    (bus.slave)
    );

    uart_io_bridge #(.DEPTH(DEPTH), .BASE_ID(BASE), .LOOPBACK(1'b1)) dut_lb (
        .clk100 (clk100),
        .reset  (reset),
        .bus    (lb_bus.slave)
    );

    // All bus tasks start and end on a falling edge: one access per rising edge.
    task automatic io_write(input logic [7:0] id, input logic [7:0] d);
        bus.IO_port_ID      = id;
        bus.IO_write_data   = d;
        bus.IO_write_strobe = 1'b1;
        @(negedge clk100);
        bus.IO_write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] id, output logic [7:0] d);
        bus.IO_port_ID     = id;
        bus.IO_read_strobe = 1'b1;
        #1 d = bus.IO_read_data;
        @(negedge clk100);
        bus.IO_read_strobe = 1'b0;
    endtask

    task automatic lb_write(input logic [7:0] id, input logic [7:0] d);
        lb_bus.IO_port_ID      = id;
        lb_bus.IO_write_data   = d;
        lb_bus.IO_write_strobe = 1'b1;
        @(negedge clk100);
        lb_bus.IO_write_strobe = 1'b0;
    endtask

    task automatic lb_read(input logic [7:0] id, output logic [7:0] d);
        lb_bus.IO_port_ID     = id;
        lb_bus.IO_read_strobe = 1'b1;
        #1 d = lb_bus.IO_read_data;
        @(negedge clk100);
        lb_bus.IO_read_strobe = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
        checks++; if (bus.rx_ready !== 1'b1) begin errors++;
            $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
        checks++; if (bus.irq !== 1'b0) begin errors++;
            $display("FAIL reset_irq: got %b want 0", bus.irq); end
        checks++; if (bus.IO_read_data !== 8'h00) begin errors++;
            $display("FAIL reset_rdata_idle: got %h want 00", bus.IO_read_data); end
        checks++; if (lb_bus.rx_ready !== 1'b0) begin errors++;
            $display("FAIL reset_lb_rx_ready: got %b want 0", lb_bus.rx_ready); end
        checks++; if (lb_bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL reset_lb_tx_valid: got %b want 0", lb_bus.tx_valid); end
    endtask

    task automatic test_tx_fwft();
        io_write(BASE, 8'hA5);
        io_write(BASE, 8'h3C);
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin errors++;
            $display("FAIL fwft_head: got v=%b d=%h want v=1 d=a5", bus.tx_valid, bus.tx_data); end
        bus.tx_ready = 1'b1;
        @(negedge clk100);
        bus.tx_ready = 1'b0;
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h3C) begin errors++;
            $display("FAIL fwft_second: got v=%b d=%h want v=1 d=3c", bus.tx_valid, bus.tx_data); end
        bus.tx_ready = 1'b1;
        @(negedge clk100);
        bus.tx_ready = 1'b0;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL fwft_drained: got %b want 0", bus.tx_valid); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] v;
        for (int i = 0; i <= DEPTH; i++) io_write(BASE, 8'h10 + 8'(i));
        io_read(BASE + 8'd2, v);
        checks++; if (v !== 8'hFF) begin errors++;
            $display("FAIL ovf_txfull: got %h want ff", v); end
        io_read(BASE + 8'd3, v);
        checks++; if (v !== 8'h82) begin errors++;
            $display("FAIL ovf_stat: got %h want 82", v); end
        checks++; if (bus.irq !== 1'b1) begin errors++;
            $display("FAIL ovf_irq: got %b want 1", bus.irq); end
        io_write(BASE + 8'd3, 8'h80);
        io_read(BASE + 8'd3, v);
        checks++; if (v !== 8'h02) begin errors++;
            $display("FAIL ovf_clear: got %h want 02", v); end
        checks++; if (bus.irq !== 1'b0) begin errors++;
            $display("FAIL ovf_irq_clear: got %b want 0", bus.irq); end
        for (int i = 0; i < DEPTH; i++) begin
            bus.tx_ready = 1'b1;
            checks++; if (bus.tx_data !== 8'h10 + 8'(i)) begin errors++;
                $display("FAIL ovf_drain[%0d]: got %h want %h", i, bus.tx_data, 8'h10 + 8'(i)); end
            @(negedge clk100);
        end
        bus.tx_ready = 1'b0;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL ovf_last_absent: got tx_valid %b want 0", bus.tx_valid); end
    endtask

    task automatic test_tx_full_pushpop();
        logic [7:0] v;
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) io_write(BASE, 8'h20 + 8'(i));
        bus.tx_ready = 1'b1;
        io_write(BASE, 8'hEE);
        bus.tx_ready = 1'b0;
        io_read(BASE + 8'd3, v);
        checks++; if (v !== 8'h02) begin errors++;
            $display("FAIL pushpop_stat: got %h want 02", v); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = (i == DEPTH - 1) ? 8'hEE : 8'h21 + 8'(i);
            bus.tx_ready = 1'b1;
            checks++; if (bus.tx_data !== exp) begin errors++;
                $display("FAIL pushpop_drain[%0d]: got %h want %h", i, bus.tx_data, exp); end
            @(negedge clk100);
        end
        bus.tx_ready = 1'b0;
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL pushpop_empty: got %b want 0", bus.tx_valid); end
    endtask

    task automatic test_rx();
        logic [7:0] v;
        bus.rx_data  = 8'h04;
        bus.rx_valid = 1'b1;
        checks++; if (bus.rx_ready !== 1'b1) begin errors++;
            $display("FAIL rx_ready: got %b want 1", bus.rx_ready); end
        @(negedge clk100);
        bus.rx_valid = 1'b0;
        checks++; if (bus.irq !== 1'b1) begin errors++;
            $display("FAIL rx_irq: got %b want 1", bus.irq); end
        io_read(BASE + 8'd1, v);
        checks++; if (v !== 8'hFF) begin errors++;
            $display("FAIL rx_pres: got %h want ff", v); end
        io_read(BASE, v);
        checks++; if (v !== 8'h04) begin errors++;
            $display("FAIL rx_data: got %h want 04", v); end
        io_read(BASE + 8'd1, v);
        checks++; if (v !== 8'h00) begin errors++;
            $display("FAIL rx_pres_after: got %h want 00", v); end
        checks++; if (bus.irq !== 1'b0) begin errors++;
            $display("FAIL rx_irq_after: got %b want 0", bus.irq); end
    endtask

    task automatic test_underflow();
        logic [7:0] v;
        io_read(BASE, v);
        checks++; if (v !== 8'h00) begin errors++;
            $display("FAIL unf_data: got %h want 00", v); end
        io_read(BASE + 8'd3, v);
        checks++; if (v !== 8'h48) begin errors++;
            $display("FAIL unf_stat: got %h want 48", v); end
        checks++; if (bus.irq !== 1'b1) begin errors++;
            $display("FAIL unf_irq: got %b want 1", bus.irq); end
        io_read(8'h7F, v);
        checks++; if (v !== 8'hFF) begin errors++;
            $display("FAIL unmapped_read: got %h want ff", v); end
        io_write(8'h7F, 8'h12);
        io_write(BASE + 8'd1, 8'h55);
        io_write(BASE + 8'd2, 8'h55);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL ignored_writes: got tx_valid %b want 0", bus.tx_valid); end
        io_write(BASE + 8'd3, 8'h40);
        io_read(BASE + 8'd3, v);
        checks++; if (v !== 8'h08) begin errors++;
            $display("FAIL unf_clear: got %h want 08", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h11;
        @(negedge clk100);
        bus.rx_data  = 8'h22;
        @(negedge clk100);
        bus.rx_valid = 1'b0;
        bus.IO_port_ID     = BASE;
        bus.IO_read_strobe = 1'b1;
        #1;
        checks++; if (bus.IO_read_data !== 8'h11) begin errors++;
            $display("FAIL b2b_first: got %h want 11", bus.IO_read_data); end
        @(negedge clk100);
        #1;
        checks++; if (bus.IO_read_data !== 8'h22) begin errors++;
            $display("FAIL b2b_second: got %h want 22", bus.IO_read_data); end
        @(negedge clk100);
        bus.IO_read_strobe = 1'b0;
        io_read(BASE + 8'd3, v);
        checks++; if (v !== 8'h08) begin errors++;
            $display("FAIL b2b_stat: got %h want 08", v); end
    endtask

    task automatic test_loopback();
        logic [7:0] v;
        lb_write(BASE, 8'h55);
        checks++; if (lb_bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL lb_tx_valid0: got %b want 0", lb_bus.tx_valid); end
        @(negedge clk100);
        checks++; if (lb_bus.tx_valid !== 1'b0 || lb_bus.rx_ready !== 1'b0) begin errors++;
            $display("FAIL lb_handshake: got v=%b r=%b want 0 0", lb_bus.tx_valid, lb_bus.rx_ready); end
        lb_read(BASE + 8'd1, v);
        checks++; if (v !== 8'hFF) begin errors++;
            $display("FAIL lb_pres: got %h want ff", v); end
        lb_read(BASE, v);
        checks++; if (v !== 8'h55) begin errors++;
            $display("FAIL lb_data: got %h want 55", v); end
        lb_read(BASE + 8'd3, v);
        checks++; if (v !== 8'h08) begin errors++;
            $display("FAIL lb_stat: got %h want 08", v); end
    endtask

    task automatic test_rx_full_reset();
        logic [7:0] v;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.rx_data = 8'h30 + 8'(i);
            @(negedge clk100);
        end
        bus.rx_data = 8'h99;
        checks++; if (bus.rx_ready !== 1'b0) begin errors++;
            $display("FAIL rxfull_ready: got %b want 0", bus.rx_ready); end
        io_read(BASE + 8'd3, v);
        checks++; if (v !== 8'h0D) begin errors++;
            $display("FAIL rxfull_stat: got %h want 0d", v); end
        io_write(BASE, 8'h77);
        checks++; if (bus.tx_valid !== 1'b1) begin errors++;
            $display("FAIL rxfull_tx: got %b want 1", bus.tx_valid); end
        // Reset lands while a write and an RX byte are both being offered.
        bus.IO_port_ID      = BASE;
        bus.IO_write_data   = 8'h66;
        bus.IO_write_strobe = 1'b1;
        reset = 1'b1;
        #1;
        checks++; if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got r=%b v=%b irq=%b want 1 0 0",
                     bus.rx_ready, bus.tx_valid, bus.irq);
        end
        @(negedge clk100);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL reset_no_access: got tx_valid %b want 0", bus.tx_valid); end
        reset = 1'b0;
        bus.IO_write_strobe = 1'b0;
        bus.rx_valid = 1'b0;
        io_read(BASE + 8'd1, v);
        checks++; if (v !== 8'h00) begin errors++;
            $display("FAIL postreset_pres: got %h want 00", v); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++;
            $display("FAIL postreset_tx: got %b want 0", bus.tx_valid); end
    endtask

    initial begin
        bus.IO_port_ID      = BASE;
        bus.IO_write_data   = 8'h00;
        bus.IO_write_strobe = 1'b0;
        bus.IO_read_strobe  = 1'b0;
        bus.tx_ready        = 1'b0;
        bus.rx_data         = 8'h00;
        bus.rx_valid        = 1'b0;
        lb_bus.IO_port_ID      = BASE;
        lb_bus.IO_write_data   = 8'h00;
        lb_bus.IO_write_strobe = 1'b0;
        lb_bus.IO_read_strobe  = 1'b0;
        // Loopback instance must ignore these.
        lb_bus.tx_ready        = 1'b1;
        lb_bus.rx_data         = 8'hAA;
        lb_bus.rx_valid        = 1'b1;
        reset = 1'b1;
        #1;
        test_reset();
        @(negedge clk100);
        reset = 1'b0;
        test_tx_fwft();
        test_tx_overflow();
        test_tx_full_pushpop();
        test_rx();
        test_underflow();
        test_back_to_back();
        test_loopback();
        test_rx_full_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
